counter_run_scheduler: RTL



---
 rtl/counter_run_scheduler_pkg.sv | 41 ++++
 rtl/counter_run_scheduler_updown_load_counter.sv | 27 ++
 rtl/counter_run_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/counter_run_scheduler_pkg.sv
// Shared types and helpers for the counter run scheduler.
// State encoding, direction constants and round-robin pick.
package counter_run_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned MAXREQ = 8;

  // First set request scanning upward from last+1, wrapping at nreq.
  function automatic logic [2:0] rr_pick(
    input logic [7:0]  req,
    input logic [2:0]  last,
    input int unsigned nreq
  );
    logic [2:0]  w;
    logic [2:0]  idx3;
    int unsigned idx;
    bit          found;
    w     = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAXREQ; k++) begin
      if (k <= nreq) begin
        idx  = (32'(last) + k) % nreq;
        idx3 = idx[2:0];
        if (!found && req[idx3]) begin
          w     = idx3;
          found = 1'b1;
        end
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/counter_run_scheduler_updown_load_counter.sv
// Loadable up/down counter shared by all runs.
// Load wins over enable; steps wrap modulo 2^CW.
module updown_load_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  input  logic          up,
  output logic [CW-1:0] count
);

  // Counter register: clear, load, or step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      if (up) count <= count + 1'b1;
      else    count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/counter_run_scheduler.sv
// Round-robin scheduler owning one shared counter.
// Grants a run, steps it to its terminal, pulses done.
module counter_run_scheduler
  import counter_run_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    dir,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               abort,
  output logic               busy,
  output logic [CW-1:0]      count
);

  state_t          state, state_d;
  logic [NREQ-1:0] grant_d;
  logic [NREQ-1:0] win_oh;
  logic [2:0]      last, last_d;
  logic [2:0]      win;
  logic            win_dir, win_dir_d;
  logic [CW-1:0]   win_len, win_len_d;
  logic            abort_d;
  logic [7:0]      req8;
  logic            sel_dir;
  logic [CW-1:0]   sel_len;
  logic            own_req;
  logic [CW-1:0]   step;
  logic [CW-1:0]   term;
  logic            ld;
  logic [CW-1:0]   ld_val;
  logic            en;
  logic            up;

  updown_load_counter #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .en       (en),
    .up       (up),
    .count    (count)
  );

  // Arbitration winner and its run parameters.
  always_comb begin
    req8 = '0;
    req8[NREQ-1:0] = req;
    win = rr_pick(req8, last, NREQ);
    win_oh  = '0;
    sel_dir = DIR_DOWN;
    sel_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == 3'(i)) begin
        win_oh[i] = 1'b1;
        sel_dir   = dir[i];
        sel_len   = len[i*CW +: CW];
      end
    end
  end

  // Owner still requesting, next step value and run terminal.
  always_comb begin
    own_req = |(req & grant);
    step = (win_dir == DIR_UP) ? count + 1'b1 : count - 1'b1;
    term = (win_dir == DIR_UP) ? win_len : '0;
  end

  // Next-state and counter control.
  always_comb begin
    state_d   = state;
    grant_d   = grant;
    last_d    = last;
    win_dir_d = win_dir;
    win_len_d = win_len;
    abort_d   = 1'b0;
    ld        = 1'b0;
    ld_val    = '0;
    en        = 1'b0;
    up        = win_dir;
    unique case (state)
      IDLE: begin
        if (|req) begin
          grant_d   = win_oh;
          last_d    = win;
          win_dir_d = sel_dir;
          win_len_d = sel_len;
          ld        = 1'b1;
          ld_val    = (sel_dir == DIR_UP) ? '0 : sel_len;
          state_d   = (sel_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!own_req) begin
          state_d = IDLE;
          grant_d = '0;
          abort_d = 1'b1;
        end else begin
          en = 1'b1;
          if (step == term) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Scheduler state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      last    <= 3'(NREQ - 1);
      win_dir <= DIR_DOWN;
      win_len <= '0;
      abort   <= 1'b0;
    end else begin
      state   <= state_d;
      grant   <= grant_d;
      last    <= last_d;
      win_dir <= win_dir_d;
      win_len <= win_len_d;
      abort   <= abort_d;
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    done = (state == DONE) ? grant : '0;
    busy = (state != IDLE);
  end

endmodule
